// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: ALU function codes,
// the sequencer state encoding and the default datapath width.
package alu_pkg;

   localparam int WIDTH_DEF = 16;

   localparam logic [1:0] FUN_ADD = 2'b00;
   localparam logic [1:0] FUN_SUB = 2'b01;
   localparam logic [1:0] FUN_AND = 2'b10;
   localparam logic [1:0] FUN_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two async operand read ports, one async debug read
// port, one synchronous write port, cleared by the asynchronous reset.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREG  = 4,
   localparam int AW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    rd_addr_a,
   output logic [WIDTH-1:0] rd_data_a,
   input  logic [AW-1:0]    rd_addr_b,
   output logic [WIDTH-1:0] rd_data_b,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data
);

   logic [WIDTH-1:0] mem [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '{default: '0};
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a = mem[rd_addr_a];
   assign rd_data_b = mem[rd_addr_b];
   assign dbg_data  = mem[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side driver for a combinational 16-bit ALU: accepts load/ALU
// commands, holds operands for ALU_LAT cycles, writes Z back and returns it.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int NREG    = 4,
   parameter int ALU_LAT = 1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_load,
   input  logic [1:0]       cmd_fun,
   input  logic [AW-1:0]    cmd_dst,
   input  logic [AW-1:0]    cmd_srca,
   input  logic [AW-1:0]    cmd_srcb,
   input  logic             cmd_imm_en,
   input  logic [WIDTH-1:0] cmd_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_fun,
   input  logic [WIDTH-1:0] alu_z,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [AW-1:0]    res_dst,
   output logic             res_zero,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   localparam int CW = $clog2(ALU_LAT + 1);

   state_t           state;
   state_t           nextState;
   logic             accept;
   logic             capture;
   logic [CW-1:0]    count;
   logic [AW-1:0]    dstReg;
   logic [WIDTH-1:0] rdDataA;
   logic [WIDTH-1:0] rdDataB;
   logic             wrEn;
   logic [AW-1:0]    wrAddr;
   logic [WIDTH-1:0] wrData;

   alu_regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (cmd_srca),
      .rd_data_a (rdDataA),
      .rd_addr_b (cmd_srcb),
      .rd_data_b (rdDataB),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .wr_en     (wrEn),
      .wr_addr   (wrAddr),
      .wr_data   (wrData)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Loads and ALU captures share the single write port; they never coincide.
   always_comb begin
      nextState = state;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept    = 1'b1;
               nextState = cmd_load ? RESP : EXEC;
            end
         end
         EXEC: begin
            if (count == CW'(1)) begin
               capture   = 1'b1;
               nextState = RESP;
            end
         end
         RESP: begin
            if (res_ready) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
      wrEn   = (accept && cmd_load) || capture;
      wrAddr = capture ? dstReg : cmd_dst;
      wrData = capture ? alu_z : cmd_imm;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_dst   <= '0;
         res_zero  <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_fun   <= '0;
         dstReg    <= '0;
         count     <= '0;
      end else begin
         cmd_ready <= (nextState == IDLE);
         res_valid <= (nextState == RESP);
         if (accept && cmd_load) begin
            res_data <= cmd_imm;
            res_dst  <= cmd_dst;
            res_zero <= (cmd_imm == '0);
         end
         if (accept && !cmd_load) begin
            alu_a   <= rdDataA;
            alu_b   <= cmd_imm_en ? cmd_imm : rdDataB;
            alu_fun <= cmd_fun;
            dstReg  <= cmd_dst;
            count   <= CW'(ALU_LAT);
         end
         if (state == EXEC) begin
            count <= count - CW'(1);
         end
         if (capture) begin
            res_data <= alu_z;
            res_dst  <= dstReg;
            res_zero <= (alu_z == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: directed vector table, hand-written stall/reset
// sequences and random commands against a register-array reference model.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int LAT = 3;

   typedef struct {
      logic        load;
      logic [1:0]  fun;
      logic [1:0]  dst;
      logic [1:0]  srca;
      logic [1:0]  srcb;
      logic        immEn;
      logic [15:0] imm;
      logic [15:0] expData;
      int          hold;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_load = 1'b0;
   logic [1:0]  cmd_fun = '0;
   logic [1:0]  cmd_dst = '0;
   logic [1:0]  cmd_srca = '0;
   logic [1:0]  cmd_srcb = '0;
   logic        cmd_imm_en = 1'b0;
   logic [15:0] cmd_imm = '0;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [1:0]  alu_fun;
   logic [15:0] alu_z;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_data;
   logic [1:0]  res_dst;
   logic        res_zero;
   logic [1:0]  dbg_addr = '0;
   logic [15:0] dbg_data;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] model [4];
   vec_t        vecs [9];

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(16), .NREG(4), .ALU_LAT(LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_load   (cmd_load),
      .cmd_fun    (cmd_fun),
      .cmd_dst    (cmd_dst),
      .cmd_srca   (cmd_srca),
      .cmd_srcb   (cmd_srcb),
      .cmd_imm_en (cmd_imm_en),
      .cmd_imm    (cmd_imm),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_fun    (alu_fun),
      .alu_z      (alu_z),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_dst    (res_dst),
      .res_zero   (res_zero),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   function automatic logic [15:0] refOp(input logic [1:0] fun, input logic [15:0] a, input logic [15:0] b);
      case (fun)
         FUN_ADD: return a + b;
         FUN_SUB: return a - b;
         FUN_AND: return a & b;
         default: return a | b;
      endcase
   endfunction

   // Stand-in for the attached combinational ALU16_bit.
   always_comb alu_z = refOp(alu_fun, alu_a, alu_b);

   function automatic vec_t mkVec(input logic load, input logic [1:0] fun, input logic [1:0] dst,
                                  input logic [1:0] srca, input logic [1:0] srcb, input logic immEn,
                                  input logic [15:0] imm, input logic [15:0] expData, input int hold);
      vec_t v;
      v.load = load; v.fun = fun; v.dst = dst; v.srca = srca; v.srcb = srcb;
      v.immEn = immEn; v.imm = imm; v.expData = expData; v.hold = hold;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic sendCommand(input vec_t v);
      int n;
      cmd_load = v.load; cmd_fun = v.fun; cmd_dst = v.dst; cmd_srca = v.srca;
      cmd_srcb = v.srcb; cmd_imm_en = v.immEn; cmd_imm = v.imm; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) checkOutput("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      int lat;
      logic [15:0] expA, expB;
      expA = model[v.srca];
      expB = v.immEn ? v.imm : model[v.srcb];
      sendCommand(v);
      if (!v.load) begin
         checkOutput("alu_a", 32'(alu_a), 32'(expA));
         checkOutput("alu_b", 32'(alu_b), 32'(expB));
         checkOutput("alu_fun", 32'(alu_fun), 32'(v.fun));
         checkOutput("cmd_ready_exec", 32'(cmd_ready), 32'd0);
      end
      lat = 0;
      while (!res_valid && lat < LAT + 5) begin
         tick();
         lat++;
      end
      if (!v.load) checkOutput("latency", 32'(lat), 32'(LAT));
      checkOutput("res_valid", 32'(res_valid), 32'd1);
      checkOutput("res_data", 32'(res_data), 32'(v.expData));
      checkOutput("res_dst", 32'(res_dst), 32'(v.dst));
      checkOutput("res_zero", 32'(res_zero), 32'(v.expData == 16'h0));
      dbg_addr = v.dst;
      #1;
      checkOutput("dbg_writeback", 32'(dbg_data), 32'(v.expData));
      for (int i = 0; i < v.hold; i++) begin
         tick();
         checkOutput("hold_res_valid", 32'(res_valid), 32'd1);
         checkOutput("hold_res_data", 32'(res_data), 32'(v.expData));
         checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checkOutput("res_valid_clear", 32'(res_valid), 32'd0);
      checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      model[v.dst] = v.expData;
   endtask

   task automatic checkAllRegs(input string name);
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1;
         checkOutput(name, 32'(dbg_data), 32'(model[i]));
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vec_t v;
      logic [15:0] a, b;

      for (int i = 0; i < 4; i++) model[i] = '0;
      vecs[0] = mkVec(1'b1, FUN_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 16'h000B, 16'h000B, 0);
      vecs[1] = mkVec(1'b1, FUN_ADD, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0269, 16'h0269, 0);
      vecs[2] = mkVec(1'b0, FUN_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 16'h0274, 0);
      vecs[3] = mkVec(1'b0, FUN_SUB, 2'd3, 2'd0, 2'd1, 1'b0, 16'h0000, 16'hFDA2, 0);
      vecs[4] = mkVec(1'b0, FUN_AND, 2'd3, 2'd0, 2'd1, 1'b0, 16'h0000, 16'h0009, 0);
      vecs[5] = mkVec(1'b0, FUN_OR,  2'd3, 2'd0, 2'd1, 1'b0, 16'h0000, 16'h026B, 5);
      vecs[6] = mkVec(1'b0, FUN_SUB, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 0);
      vecs[7] = mkVec(1'b0, FUN_ADD, 2'd2, 2'd1, 2'd3, 1'b1, 16'hFD97, 16'h0000, 0);
      vecs[8] = mkVec(1'b0, FUN_ADD, 2'd1, 2'd1, 2'd1, 1'b0, 16'h0000, 16'h04D2, 1);

      // Reset values, and cmd_ready rising only on the first edge after release.
      tick();
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
      checkOutput("rst_res_data", 32'(res_data), 32'd0);
      checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      checkOutput("post_rst_cmd_ready_low", 32'(cmd_ready), 32'd0);
      tick();
      checkOutput("post_rst_cmd_ready_high", 32'(cmd_ready), 32'd1);
      checkAllRegs("rst_regs");

      for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);
      checkAllRegs("table_regs");

      // Reset dropped in the middle of an ALU operation.
      v = mkVec(1'b0, FUN_OR, 2'd3, 2'd1, 2'd0, 1'b1, 16'h1234, 16'h0, 0);
      sendCommand(v);
      tick();
      checkOutput("midexec_no_valid", 32'(res_valid), 32'd0);
      checkOutput("midexec_alu_b", 32'(alu_b), 32'h1234);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_alu_b", 32'(alu_b), 32'd0);
      checkOutput("arst_alu_a", 32'(alu_a), 32'd0);
      checkOutput("arst_alu_fun", 32'(alu_fun), 32'd0);
      checkOutput("arst_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("arst_res_dst", 32'(res_dst), 32'd0);
      for (int i = 0; i < 4; i++) model[i] = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      checkAllRegs("arst_regs");
      checkOutput("arst_cmd_ready_low", 32'(cmd_ready), 32'd0);
      tick();
      checkOutput("arst_cmd_ready_high", 32'(cmd_ready), 32'd1);
      checkOutput("arst_res_valid", 32'(res_valid), 32'd0);

      // Random commands against the register-array model.
      for (int n = 0; n < 40; n++) begin
         v.load  = ($urandom % 4) == 0;
         v.fun   = 2'($urandom);
         v.dst   = 2'($urandom);
         v.srca  = 2'($urandom);
         v.srcb  = 2'($urandom);
         v.immEn = 1'($urandom);
         v.imm   = 16'($urandom);
         v.hold  = int'($urandom_range(0, 3));
         a = model[v.srca];
         b = v.immEn ? v.imm : model[v.srcb];
         v.expData = v.load ? v.imm : refOp(v.fun, a, b);
         applyStimulus(v);
      end
      checkAllRegs("final_regs");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
